// File: rtl/regfile_access_master.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_access_master
//  Description : Initiator-side controller for a dual-read, single-write file
//                register. Accepts write / read-pair commands over valid/ready,
//                returns read data on a valid/ready response channel, and can
//                zero-fill the whole file after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_master #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 8,
    parameter int RD_WAIT        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic              init_done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int WAIT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

    // Clear counter is one bit wider than the address so it can reach DEPTH
    // (one past the last entry) without wrapping back to 0.
    localparam logic [CNT_W-1:0]  CLR_END   = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_WAIT);

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [WAIT_W-1:0]   wait_q,       wait_d;
    logic                init_done_q,  init_done_d;
    logic                rf_we_q,      rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q,   rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q,   rf_wdata_d;
    logic [ADDR_W-1:0]   rf_raddr1_q,  rf_raddr1_d;
    logic [ADDR_W-1:0]   rf_raddr2_q,  rf_raddr2_d;
    logic                rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_a_q, rsp_data_a_d;
    logic [DATA_W-1:0]   rsp_data_b_q, rsp_data_b_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        init_done_d  = init_done_q;
        rf_we_d      = 1'b0;            // only CLEAR and WRITE-entry raise it
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        rf_raddr1_d  = rf_raddr1_q;
        rf_raddr2_d  = rf_raddr2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_a_d = rsp_data_a_q;
        rsp_data_b_d = rsp_data_b_q;

        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CLR_END) begin
                    // Last zero-write (entry DEPTH-1) landed on this edge.
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = cnt_q[ADDR_W-1:0];
                    rf_wdata_d = '0;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = cmd_addr_a;
                        rf_wdata_d = cmd_wdata;
                        state_d    = ST_WRITE;
                    end else begin
                        rf_raddr1_d = cmd_addr_a;
                        rf_raddr2_d = cmd_addr_b;
                        wait_d      = WAIT_INIT;
                        state_d     = ST_RD_WAIT;
                    end
                end
            end
            ST_WRITE: begin
                // The file register commits at this edge; drop WE and return.
                state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                // First cycle here is the address setup cycle; RD_WAIT more
                // cycles follow before the read data is captured.
                if (wait_q == '0) begin
                    rsp_data_a_d = rf_data1;
                    rsp_data_b_d = rf_data2;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q        <= '0;
            wait_q       <= '0;
            init_done_q  <= (CLEAR_ON_RESET == 0);
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            rf_raddr1_q  <= '0;
            rf_raddr2_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            init_done_q  <= init_done_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            rf_raddr1_q  <= rf_raddr1_d;
            rf_raddr2_q  <= rf_raddr2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_a_q <= rsp_data_a_d;
            rsp_data_b_q <= rsp_data_b_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data_a = rsp_data_a_q;
    assign rsp_data_b = rsp_data_b_q;
    assign init_done  = init_done_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign rf_raddr1  = rf_raddr1_q;
    assign rf_raddr2  = rf_raddr2_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_access_master
//  Description : Self-checking bench. Three instances (RD_WAIT=0, RD_WAIT=2,
//                no-clear) each attached to a behavioural 32x8 file register.
//                A transaction-level model predicts handshakes and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_access_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] sel = 2'd0;

    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [4:0] cmd_addr_a = '0;
    logic [4:0] cmd_addr_b = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_ready = 1'b0;

    logic       ready_w   [3];
    logic       valid_w   [3];
    logic [7:0] rsp_a_w   [3];
    logic [7:0] rsp_b_w   [3];
    logic       init_w    [3];
    logic       we_w      [3];
    logic [4:0] waddr_w   [3];
    logic [7:0] wdata_w   [3];
    logic [4:0] raddr1_w  [3];
    logic [4:0] raddr2_w  [3];
    logic [7:0] rd1_w     [3];
    logic [7:0] rd2_w     [3];
    logic [7:0] mem       [3][32];

    always #5 clk = ~clk;

    regfile_access_master #(.ADDR_W(5), .DATA_W(8), .RD_WAIT(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid && (sel == 2'd0)), .cmd_ready(ready_w[0]),
        .cmd_write(cmd_write), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(valid_w[0]), .rsp_ready(rsp_ready && (sel == 2'd0)),
        .rsp_data_a(rsp_a_w[0]), .rsp_data_b(rsp_b_w[0]), .init_done(init_w[0]),
        .rf_we(we_w[0]), .rf_waddr(waddr_w[0]), .rf_wdata(wdata_w[0]),
        .rf_raddr1(raddr1_w[0]), .rf_raddr2(raddr2_w[0]),
        .rf_data1(rd1_w[0]), .rf_data2(rd2_w[0])
    );

    regfile_access_master #(.ADDR_W(5), .DATA_W(8), .RD_WAIT(2), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid && (sel == 2'd1)), .cmd_ready(ready_w[1]),
        .cmd_write(cmd_write), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(valid_w[1]), .rsp_ready(rsp_ready && (sel == 2'd1)),
        .rsp_data_a(rsp_a_w[1]), .rsp_data_b(rsp_b_w[1]), .init_done(init_w[1]),
        .rf_we(we_w[1]), .rf_waddr(waddr_w[1]), .rf_wdata(wdata_w[1]),
        .rf_raddr1(raddr1_w[1]), .rf_raddr2(raddr2_w[1]),
        .rf_data1(rd1_w[1]), .rf_data2(rd2_w[1])
    );

    regfile_access_master #(.ADDR_W(5), .DATA_W(8), .RD_WAIT(0), .CLEAR_ON_RESET(0)) u_dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid && (sel == 2'd2)), .cmd_ready(ready_w[2]),
        .cmd_write(cmd_write), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(valid_w[2]), .rsp_ready(rsp_ready && (sel == 2'd2)),
        .rsp_data_a(rsp_a_w[2]), .rsp_data_b(rsp_b_w[2]), .init_done(init_w[2]),
        .rf_we(we_w[2]), .rf_waddr(waddr_w[2]), .rf_wdata(wdata_w[2]),
        .rf_raddr1(raddr1_w[2]), .rf_raddr2(raddr2_w[2]),
        .rf_data1(rd1_w[2]), .rf_data2(rd2_w[2])
    );

    // Behavioural file registers: synchronous write, combinational read.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we_w[i]) mem[i][waddr_w[i]] <= wdata_w[i];
        end
    end

    assign rd1_w[0] = mem[0][raddr1_w[0]];
    assign rd2_w[0] = mem[0][raddr2_w[0]];
    assign rd1_w[1] = mem[1][raddr1_w[1]];
    assign rd2_w[1] = mem[1][raddr2_w[1]];
    assign rd1_w[2] = mem[2][raddr1_w[2]];
    assign rd2_w[2] = mem[2][raddr2_w[2]];

    // Outputs of the instance currently under test.
    logic       s_ready, s_valid, s_init, s_we;
    logic [4:0] s_waddr;
    logic [7:0] s_wdata, s_a, s_b;
    assign s_ready = ready_w[sel];
    assign s_valid = valid_w[sel];
    assign s_init  = init_w[sel];
    assign s_we    = we_w[sel];
    assign s_waddr = waddr_w[sel];
    assign s_wdata = wdata_w[sel];
    assign s_a     = rsp_a_w[sel];
    assign s_b     = rsp_b_w[sel];

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction-level model state.
    logic       model_on = 1'b0;
    int         model_rd = 0;
    logic [7:0] gold [32];
    logic       exp_ready, exp_valid, exp_we, wr_busy;
    logic [7:0] exp_a, exp_b, pend_a, pend_b, exp_wdata;
    logic [4:0] exp_waddr;
    int         countdown;
    logic       hs_cmd, hs_rsp;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Advance the model across the rising edge just passed, then compare.
    function automatic void model_step();
        logic cur_ready, cur_valid;
        cur_ready = exp_ready;
        cur_valid = exp_valid;
        exp_we    = 1'b0;
        if (wr_busy) begin
            wr_busy   = 1'b0;
            exp_ready = 1'b1;
        end
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                exp_valid = 1'b1;
                exp_a     = pend_a;
                exp_b     = pend_b;
            end
        end else if (cur_valid && rsp_ready) begin
            exp_valid = 1'b0;
            exp_ready = 1'b1;
        end
        if (cur_ready && cmd_valid) begin
            exp_ready = 1'b0;
            if (cmd_write) begin
                gold[cmd_addr_a] = cmd_wdata;
                exp_we    = 1'b1;
                exp_waddr = cmd_addr_a;
                exp_wdata = cmd_wdata;
                wr_busy   = 1'b1;
            end else begin
                pend_a    = gold[cmd_addr_a];
                pend_b    = gold[cmd_addr_b];
                countdown = 1 + model_rd;
            end
        end
        check("cmd_ready", 64'(s_ready), 64'(exp_ready));
        check("rsp_valid", 64'(s_valid), 64'(exp_valid));
        if (exp_valid) check("rsp_data", {s_a, s_b}, {exp_a, exp_b});
        check("rf_we", 64'(s_we), 64'(exp_we));
        if (exp_we) check("rf_write", {s_waddr, s_wdata}, {exp_waddr, exp_wdata});
        check("init_done", 64'(s_init), 64'd1);
    endfunction

    // One clock: note what handshakes the coming edge will see, then wait.
    task automatic cyc();
        hs_cmd = cmd_valid && s_ready;
        hs_rsp = s_valid && rsp_ready;
        @(negedge clk);
        if (model_on) model_step();
    endtask

    task automatic send(input logic wr, input logic [4:0] a, input logic [4:0] b, input logic [7:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr_a = a; cmd_addr_b = b; cmd_wdata = d;
        do begin cyc(); n++; end while (!hs_cmd && n < 50);
        if (!hs_cmd) check("cmd_accept_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b0; cmd_addr_a = ~a; cmd_addr_b = ~b; cmd_wdata = ~d;
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b, input int hold,
                             input logic [7:0] ea, input logic [7:0] eb, input int elat);
        int lat, n;
        logic [15:0] got;
        send(1'b0, a, b, 8'h00);
        rsp_ready = 1'b0;
        lat = 0;
        while (!s_valid && lat < 50) begin cyc(); lat++; end
        check("rsp_latency", 64'(lat), 64'(elat));
        if (hold > 0) begin
            // A stray write while the response is parked must be ignored.
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr_a = 5'd1; cmd_wdata = 8'hEE;
        end
        repeat (hold) cyc();
        got = {s_a, s_b};
        rsp_ready = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!hs_rsp && n < 50);
        if (!hs_rsp) check("rsp_handshake_timeout", 64'd0, 64'd1);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_data_literal", 64'(got), {48'd0, ea, eb});
    endtask

    // Walk the post-reset zero-fill, then arm the model for normal traffic.
    task automatic do_clear(input int rd);
        model_on = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            check("clear_write", {s_we, s_waddr, s_wdata, s_init, s_ready},
                  {1'b1, 5'(i), 8'h00, 1'b0, 1'b0});
        end
        cyc();
        check("clear_done", {s_we, s_init, s_ready}, {1'b0, 1'b1, 1'b1});
        for (int i = 0; i < 32; i++) gold[i] = 8'h00;
        exp_ready = 1'b1; exp_valid = 1'b0; exp_we = 1'b0; wr_busy = 1'b0;
        countdown = 0; model_rd = rd;
        model_on = 1'b1;
    endtask

    initial begin
        hs_cmd = 1'b0; hs_rsp = 1'b0;
        exp_ready = 1'b0; exp_valid = 1'b0; exp_we = 1'b0; wr_busy = 1'b0;
        exp_a = '0; exp_b = '0; pend_a = '0; pend_b = '0;
        exp_waddr = '0; exp_wdata = '0; countdown = 0;

        // Reset state of all three builds.
        repeat (3) @(negedge clk);
        check("reset_outputs", {we_w[0], waddr_w[0], wdata_w[0], raddr1_w[0], raddr2_w[0],
                                valid_w[0], rsp_a_w[0], rsp_b_w[0]}, 64'd0);
        check("reset_flags", {init_w[0], ready_w[0], init_w[1], ready_w[1]}, 4'b0000);
        check("reset_flags_noclear", {init_w[2], ready_w[2], we_w[2]}, 3'b110);
        rst = 1'b1;

        // 1: full zero-fill, then read the two extreme entries.
        do_clear(0);
        check("noclear_init_done", {init_w[2], ready_w[2]}, 2'b11);
        read_pair(5'd0, 5'd31, 0, 8'h00, 8'h00, 1);

        // 2: two writes, then a read pair.
        send(1'b1, 5'd0, 5'd0, 8'h07);
        send(1'b1, 5'd1, 5'd0, 8'h09);
        read_pair(5'd0, 5'd1, 0, 8'h07, 8'h09, 1);

        // 3: same address on both lanes with response back-pressure.
        read_pair(5'd1, 5'd1, 5, 8'h09, 8'h09, 1);

        // 4: write to the top entry immediately followed by a read of it.
        send(1'b1, 5'd31, 5'd0, 8'hA5);
        read_pair(5'd31, 5'd0, 0, 8'hA5, 8'h07, 1);

        // 5: asynchronous reset in the middle of a clear.
        model_on = 1'b0;
        rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        repeat (10) cyc();
        check("midclear_before", {s_we, s_waddr}, {1'b1, 5'd9});
        #2 rst = 1'b0;
        #1;
        check("midclear_async_zero", {s_we, s_waddr, s_wdata, s_init, s_ready, s_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_clear(0);

        // 6: RD_WAIT=2 build, rewrite and read back.
        sel = 2'd1;
        #1;
        check("rdwait_build_idle", {s_init, s_ready, s_valid}, 3'b110);
        model_rd = 2;
        send(1'b1, 5'd0, 5'd0, 8'h07);
        send(1'b1, 5'd1, 5'd0, 8'h09);
        read_pair(5'd0, 5'd1, 0, 8'h07, 8'h09, 3);
        read_pair(5'd1, 5'd31, 2, 8'h09, 8'h00, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
